// File: rtl/lsu_arbiter.sv
// ---------------------------------------------------------------------------
// lsu_arbiter
//
// Two-port round-robin arbiter and sequencer in front of the load/store unit.
// Port 0 is the core pipeline, port 1 a debug/DMA master. One request is
// accepted at a time, checked for funct3 legality and alignment, driven onto
// the LSU bus for exactly one cycle, and answered with a registered one-cycle
// response to the requester that won. Illegal accesses never reach the bus.
//
// Ports
//   clk_i, rst_i                    clock, synchronous active-high reset
//   reqN_valid_i / reqN_ready_o     request handshake (ready only in IDLE)
//   reqN_we_i, reqN_funct3_i        1 = store; RV32 load/store funct3
//   reqN_addr_i, reqN_wdata_i       byte address, store data
//   rspN_valid_o                    one-cycle response pulse
//   rspN_rdata_o, rspN_err_o        load data (0 for stores/errors), reject
//   lsu_st_en_o                     store strobe, high only during BUS
//   lsu_funct3_o, lsu_addr_o,
//   lsu_st_data_o                   latched request towards the LSU
//   lsu_ld_data_i                   combinational load data from the LSU
//   busy_o                          arbiter is not idle
// ---------------------------------------------------------------------------
module lsu_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic              req0_we_i,
    input  logic [2:0]        req0_funct3_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_wdata_i,

    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic              req1_we_i,
    input  logic [2:0]        req1_funct3_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_wdata_i,

    output logic              rsp0_valid_o,
    output logic [DATA_W-1:0] rsp0_rdata_o,
    output logic              rsp0_err_o,

    output logic              rsp1_valid_o,
    output logic [DATA_W-1:0] rsp1_rdata_o,
    output logic              rsp1_err_o,

    output logic              lsu_st_en_o,
    output logic [2:0]        lsu_funct3_o,
    output logic [ADDR_W-1:0] lsu_addr_o,
    output logic [DATA_W-1:0] lsu_st_data_o,
    input  logic [DATA_W-1:0] lsu_ld_data_i,

    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_win_q;      // port that won the previous grant
    logic              gnt_q;           // port being served
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic              any_valid;
    logic              win;
    logic              accept;
    logic              sel_we;
    logic [2:0]        sel_funct3;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_legal;

    // Stores allow byte/half/word; loads add the unsigned byte/half forms.
    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_legal(input logic we, input logic [2:0] f3,
                                      input logic [1:0] a);
        logic ok;
        case (f3)
            3'd0:    ok = 1'b1;
            3'd1:    ok = ~a[0];
            3'd2:    ok = (a == 2'b00);
            3'd4:    ok = ~we;
            3'd5:    ok = ~we & ~a[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Port 1 wins when it is the only requester, or on a tie when port 0
    // took the previous grant.
    assign any_valid = req0_valid_i | req1_valid_i;
    assign win       = req1_valid_i & (~req0_valid_i | ~last_win_q);

    assign sel_we     = win ? req1_we_i     : req0_we_i;
    assign sel_funct3 = win ? req1_funct3_i : req0_funct3_i;
    assign sel_addr   = win ? req1_addr_i   : req0_addr_i;
    assign sel_wdata  = win ? req1_wdata_i  : req0_wdata_i;
    assign sel_legal  = is_legal(sel_we, sel_funct3, sel_addr[1:0]);

    // NOTE: every signal written here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    accept  = 1'b1;
                    state_d = sel_legal ? BUS : RESP;
                end
            end
            BUS:     state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_win_q <= 1'b1;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                gnt_q      <= win;
                last_win_q <= win;
                we_q       <= sel_we;
                funct3_q   <= sel_funct3;
                addr_q     <= sel_addr;
                wdata_q    <= sel_wdata;
                err_q      <= ~sel_legal;
                rdata_q    <= '0;
            end else if (state_q == BUS && !we_q) begin
                rdata_q <= lsu_ld_data_i;
            end
        end
    end

    // Ready is masked during reset so no handshake completes on a reset edge.
    assign req0_ready_o = accept & ~win & ~rst_i;
    assign req1_ready_o = accept &  win & ~rst_i;

    assign rsp0_valid_o = (state_q == RESP) & ~gnt_q;
    assign rsp1_valid_o = (state_q == RESP) &  gnt_q;
    assign rsp0_rdata_o = rsp0_valid_o ? rdata_q : '0;
    assign rsp1_rdata_o = rsp1_valid_o ? rdata_q : '0;
    assign rsp0_err_o   = rsp0_valid_o & err_q;
    assign rsp1_err_o   = rsp1_valid_o & err_q;

    // The store strobe is killed combinationally by reset so a store caught
    // in BUS on a reset edge never commits.
    assign lsu_st_en_o   = (state_q == BUS) & we_q & ~rst_i;
    assign lsu_funct3_o  = funct3_q;
    assign lsu_addr_o    = addr_q;
    assign lsu_st_data_o = wdata_q;

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_lsu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lsu_arbiter
//
// Self-checking bench for lsu_arbiter. Single requests come from a table of
// {request, expected response} records; contention, reset during BUS and a
// withdrawn request are hand-written sequences. Expected responses and bus
// cycles are queued when a grant is observed and compared by a monitor when
// the DUT produces them.
// ---------------------------------------------------------------------------
module tb_lsu_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;

    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic              req0_ready, req1_ready;
    logic              req0_we = 1'b0, req1_we = 1'b0;
    logic [2:0]        req0_funct3 = '0, req1_funct3 = '0;
    logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0;
    logic [DATA_W-1:0] req0_wdata = '0, req1_wdata = '0;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
    logic              rsp0_err, rsp1_err;
    logic              lsu_st_en;
    logic [2:0]        lsu_funct3;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_st_data;
    logic [DATA_W-1:0] lsu_ld_data;
    logic              busy;

    lsu_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
        .req0_we_i(req0_we), .req0_funct3_i(req0_funct3),
        .req0_addr_i(req0_addr), .req0_wdata_i(req0_wdata),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
        .req1_we_i(req1_we), .req1_funct3_i(req1_funct3),
        .req1_addr_i(req1_addr), .req1_wdata_i(req1_wdata),
        .rsp0_valid_o(rsp0_valid), .rsp0_rdata_o(rsp0_rdata), .rsp0_err_o(rsp0_err),
        .rsp1_valid_o(rsp1_valid), .rsp1_rdata_o(rsp1_rdata), .rsp1_err_o(rsp1_err),
        .lsu_st_en_o(lsu_st_en), .lsu_funct3_o(lsu_funct3),
        .lsu_addr_o(lsu_addr), .lsu_st_data_o(lsu_st_data),
        .lsu_ld_data_i(lsu_ld_data),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Memory model behind the LSU: one fixed word, otherwise address-derived.
    function automatic logic [31:0] ld_model(input logic [15:0] a);
        return (a == 16'h2004) ? 32'hDEADBEEF : {~a, a};
    endfunction
    assign lsu_ld_data = ld_model(lsu_addr);

    typedef struct {
        logic        port;
        logic        we;
        logic [2:0]  f3;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_exp_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [15:0] addr;
        logic [31:0] data;
        int          cyc;
    } bus_exp_t;

    rsp_exp_t sb[$];
    bus_exp_t bq[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic set_req(input int p, input logic v, input logic we, input logic [2:0] f3,
                           input logic [15:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0_valid = v; req0_we = we; req0_funct3 = f3; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_funct3 = f3; req1_addr = a; req1_wdata = d;
        end
    endtask

    function automatic logic ready_of(input int p);
        return (p == 0) ? req0_ready : req1_ready;
    endfunction

    task automatic push_exp(input int p, input logic we, input logic [2:0] f3,
                            input logic [15:0] a, input logic [31:0] d,
                            input logic err, input logic [31:0] rdata, input int acc);
        rsp_exp_t r;
        bus_exp_t b;
        r.port = p[0]; r.rdata = rdata; r.err = err; r.cyc = acc + (err ? 1 : 2);
        sb.push_back(r);
        if (!err) begin
            b.we = we; b.f3 = f3; b.addr = a; b.data = d; b.cyc = acc + 1;
            bq.push_back(b);
        end
    endtask

    // Raise one request, wait (bounded) for its grant, queue expectations,
    // and drop valid after the accepting edge. Returns in the cycle after
    // acceptance.
    task automatic issue(input vec_t v, input bit track, output int acc);
        bit got = 0;
        acc = -1;
        @(posedge clk); #1;
        set_req(int'(v.port), 1'b1, v.we, v.f3, v.addr, v.wdata);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ready_of(int'(v.port))) got = 1;
        end
        check("ready_seen", 64'(got), 64'd1);
        if (got) begin
            acc = cyc;
            if (track) push_exp(int'(v.port), v.we, v.f3, v.addr, v.wdata,
                                v.exp_err, v.exp_rdata, acc);
        end
        @(posedge clk); #1;
        set_req(int'(v.port), 1'b0, 1'b0, 3'd0, 16'h0, 32'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && (sb.size() != 0 || bq.size() != 0); i++) @(negedge clk);
        if (sb.size() != 0 || bq.size() != 0) begin
            fail("drain_timeout");
            sb.delete();
            bq.delete();
        end
    endtask

    function automatic logic [15:0] c_addr(input int p, input int k);
        return 16'h7000 + ((p != 0) ? 16'h0100 : 16'h0000) + 16'(k * 4);
    endfunction
    function automatic logic [31:0] c_data(input int p, input int k);
        return 32'hC0DE0000 | 32'(p << 8) | 32'(k);
    endfunction

    // Both ports hold valid with n word stores each; grants must alternate
    // starting with port 0, three cycles apart.
    task automatic contend(input int n);
        int idx[2];
        int exp_p = 0;
        int last_acc = -1;
        int p;
        bit upd;
        idx[0] = 0; idx[1] = 0;
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b1, 3'd2, c_addr(0, 0), c_data(0, 0));
        set_req(1, 1'b1, 1'b1, 3'd2, c_addr(1, 0), c_data(1, 0));
        for (int c = 0; c < 200 && (idx[0] < n || idx[1] < n); c++) begin
            upd = 0;
            p = 0;
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                p = req1_ready ? 1 : 0;
                check("grant_port", 64'(p), 64'(exp_p));
                if (last_acc >= 0) check("grant_gap", 64'(cyc - last_acc), 64'd3);
                last_acc = cyc;
                push_exp(p, 1'b1, 3'd2, c_addr(p, idx[p]), c_data(p, idx[p]), 1'b0, 32'h0, cyc);
                idx[p]++;
                exp_p = (idx[1-p] < n) ? (1 - p) : p;
                upd = 1;
            end
            @(posedge clk); #1;
            if (upd) begin
                if (idx[p] < n) set_req(p, 1'b1, 1'b1, 3'd2, c_addr(p, idx[p]), c_data(p, idx[p]));
                else            set_req(p, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0);
            end
        end
        if (idx[0] < n || idx[1] < n) fail("contend_timeout");
        set_req(0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0);
    endtask

    // Monitor: handshake rules, response scoreboard and LSU bus cycles.
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_ready && !req0_valid) fail("ready0_without_valid");
            if (req1_ready && !req1_valid) fail("ready1_without_valid");
            if (req0_ready && req1_ready)  fail("dual_ready");

            if (rsp0_valid && rsp1_valid) begin
                fail("dual_rsp");
            end else if (rsp0_valid || rsp1_valid) begin
                if (sb.size() == 0) begin
                    fail("rsp_unexpected");
                end else begin
                    rsp_exp_t e;
                    e = sb.pop_front();
                    check("rsp_port",  64'(rsp1_valid), 64'(e.port));
                    check("rsp_rdata", 64'(rsp1_valid ? rsp1_rdata : rsp0_rdata), 64'(e.rdata));
                    check("rsp_err",   64'(rsp1_valid ? rsp1_err : rsp0_err), 64'(e.err));
                    check("rsp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (sb.size() != 0 && sb[0].cyc < cyc) begin
                fail("rsp_missing");
                void'(sb.pop_front());
            end

            if (bq.size() != 0 && bq[0].cyc == cyc) begin
                bus_exp_t b;
                b = bq.pop_front();
                check("bus_st_en",  64'(lsu_st_en), 64'(b.we));
                check("bus_addr",   64'(lsu_addr), 64'(b.addr));
                check("bus_funct3", 64'(lsu_funct3), 64'(b.f3));
                if (b.we) check("bus_st_data", 64'(lsu_st_data), 64'(b.data));
            end else if (lsu_st_en) begin
                fail("st_en_unexpected");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    vec_t vecs[12];
    int   acc, prev_acc;
    logic prev_err;

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 3'd2, 16'h2004, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b0, 3'd2, 16'h2002, 32'h0,        1'b1, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 3'd4, 16'h2000, 32'h55,       1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 3'd0, 16'h7000, 32'h000000A5, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 3'd5, 16'h2001, 32'h0,        1'b1, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 3'd4, 16'h2003, 32'h0,        1'b0, ld_model(16'h2003)};
        vecs[6]  = '{1'b0, 1'b1, 3'd1, 16'h3002, 32'h0000BEEF, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 3'd3, 16'h2000, 32'h0,        1'b1, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 3'd2, 16'h3001, 32'h12345678, 1'b1, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 3'd1, 16'h2006, 32'h0,        1'b0, ld_model(16'h2006)};
        vecs[10] = '{1'b0, 1'b0, 3'd0, 16'h2009, 32'h0,        1'b0, ld_model(16'h2009)};
        vecs[11] = '{1'b1, 1'b1, 3'd6, 16'h2000, 32'h1,        1'b1, 32'h0};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready",   64'({req0_ready, req1_ready}), 64'd0);
        check("rst_rsp",     64'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}), 64'd0);
        check("rst_rdata",   64'({rsp0_rdata, rsp1_rdata}), 64'd0);
        check("rst_st_en",   64'(lsu_st_en), 64'd0);
        check("rst_busy",    64'(busy), 64'd0);
        check("rst_bus_val", 64'({lsu_addr, lsu_funct3, lsu_st_data}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single requests; spacing between grants is 3 cycles after a legal
        // access and 2 after an illegal one.
        prev_acc = -1;
        prev_err = 1'b0;
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i], 1'b1, acc);
            if (prev_acc >= 0) check("accept_gap", 64'(acc - prev_acc), prev_err ? 64'd2 : 64'd3);
            prev_acc = acc;
            prev_err = vecs[i].exp_err;
        end
        drain();

        contend(4);
        drain();

        // Reset during BUS of a port 0 store: strobe suppressed, no response,
        // and the next tie goes to port 0 even though port 0 won last.
        issue('{1'b0, 1'b1, 3'd2, 16'h7004, 32'h11223344, 1'b0, 32'h0}, 1'b0, acc);
        rst = 1'b1;
        @(negedge clk);
        check("rst_bus_st_en", 64'(lsu_st_en), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_rsp",  64'({rsp0_valid, rsp1_valid}), 64'd0);
        contend(1);
        drain();

        // Port 0 raises and withdraws a request while port 1 is served.
        @(posedge clk); #1;
        set_req(1, 1'b1, 1'b0, 3'd2, 16'h2008, 32'h0);
        begin
            bit got = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (req1_ready) got = 1;
            end
            check("wd_ready1", 64'(got), 64'd1);
            if (got) push_exp(1, 1'b0, 3'd2, 16'h2008, 32'h0, 1'b0, ld_model(16'h2008), cyc);
        end
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0);
        set_req(0, 1'b1, 1'b0, 3'd2, 16'h2010, 32'h0);
        @(negedge clk);
        check("wd_ready0_bus", 64'(req0_ready), 64'd0);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 3'd0, 16'h0, 32'h0);
        @(negedge clk);
        check("wd_ready0_resp", 64'(req0_ready), 64'd0);
        @(negedge clk);
        check("wd_busy_idle", 64'(busy), 64'd0);
        check("wd_ready0_idle", 64'(req0_ready), 64'd0);
        drain();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_arbiter.md
# lsu_arbiter

Two-port arbiter and sequencer in front of the load/store unit. The core pipeline (port 0) and a debug/DMA master (port 1) share the LSU through it. It accepts one request at a time under round-robin priority, drives it onto the LSU bus for exactly one cycle, and returns a registered response to the winning requester. It checks alignment and funct3 legality before issue, so that illegal accesses never reach data memory or peripherals.

## Interface
Parameters:
- ADDR_W, 16, LSU address width
- DATA_W, 32, store/load data width

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; synchronous, active-high
- reqN_valid_i  in  1  request N valid (N = 0, 1)
- reqN_ready_o  out  1  request N accepted this cycle
- reqN_we_i  in  1  1 = store, 0 = load
- reqN_funct3_i  in  3  RV32 load/store funct3
- reqN_addr_i  in  ADDR_W  byte address
- reqN_wdata_i  in  DATA_W  store data
- rspN_valid_o  out  1  response N valid (one-cycle pulse)
- rspN_rdata_o  out  DATA_W  load data; 0 for stores and errors
- rspN_err_o  out  1  access rejected (qualified by rspN_valid_o)
- lsu_st_en_o  out  1  LSU store enable
- lsu_funct3_o  out  3  LSU funct3
- lsu_addr_o  out  ADDR_W  LSU address
- lsu_st_data_o  out  DATA_W  LSU store data
- lsu_ld_data_i  in  DATA_W  LSU combinational load data
- busy_o  out  1  state != IDLE

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - If any reqN_valid_i is high, select the winner, assert its reqN_ready_o combinationally, and latch we/funct3/addr/wdata plus the grant id.
  - Go to BUS if the access is legal, otherwise go to RESP with err = 1.
- Arbitration:
  - If only one valid is high, that port wins.
  - If both are high, the port that did not win last time wins.
  - The last-winner register is 1 after reset, so port 0 wins the first tie.
- Legality:
  - Stores accept funct3 0, 1, 2. Loads accept 0, 1, 2, 4, 5. Any other funct3 is an error.
  - Alignment: halfword (1, 5) requires addr[0] = 0. Word (2) requires addr[1:0] = 0.
- BUS:
  - lsu_* outputs are driven from the latched request, and lsu_st_en_o = latched we.
  - For a load, lsu_ld_data_i is captured into the response register at the end of the cycle.
  - Go to RESP.
- RESP:
  - rspN_valid_o is high for the granted port only, for one cycle. rdata is the captured value for loads and 0 otherwise. err is the latched error flag.
  - Go to IDLE.
- Outside BUS, lsu_st_en_o = 0. lsu_addr_o, lsu_funct3_o and lsu_st_data_o hold their latched values; they are don't-care to the LSU.
- A requester keeps valid and its payload stable until it sees ready. Deasserting valid before ready is allowed and withdraws the request.
- The arbiter performs no extension of load data: the LSU already sign- or zero-extends by funct3.

## Timing
- Reset values:
  - state = IDLE, last-winner = 1.
  - All reqN_ready_o, rspN_valid_o, rspN_err_o, lsu_st_en_o and busy_o = 0.
  - rspN_rdata_o, lsu_addr_o, lsu_funct3_o and lsu_st_data_o = 0.
- Legal access: accept at cycle T (IDLE), LSU bus at T+1, response at T+2. The next acceptance is possible at T+3, giving a throughput of one access per 3 cycles.
- Illegal access: accept at T, rsp valid with err at T+1, no LSU cycle. The next acceptance is possible at T+2.
- Ready is asserted only in IDLE, and never for both ports in the same cycle.
- Valid requests that arrive while busy wait; no ready is given until IDLE.
- The store write to the LSU occurs at the rising edge that ends the BUS cycle.
- rst_i asserted in any state:
  - The next edge returns to IDLE with the reset values.
  - An in-flight request is dropped with no response.
  - A store in BUS at that edge is suppressed: lsu_st_en_o is forced to 0 while rst_i is high.

## Test plan
- Single load, port 0: addr 0x2004, funct3 2, LSU returns 0xDEADBEEF. Required: ready0 at T, lsu_st_en_o = 0 with addr 0x2004 at T+1, rsp0_valid with rdata 0xDEADBEEF and err 0 at T+2.
- Contention: both ports hold valid continuously with 4 stores each. Grants alternate 0,1,0,1…. Each lsu_st_en_o pulse lasts one cycle and pulses are 3 cycles apart. No rsp is sent to the wrong port.
- Illegal accesses:
  - Port 1 word load at 0x2002: rsp1_valid with err 1 at T+1, lsu_st_en_o never high.
  - Store with funct3 4: same required response.
- Store to the output peripheral region: port 1 at addr 0x7000, funct3 0, data 0x000000A5. lsu_st_en_o high for exactly one cycle with st_data 0xA5. rsp1 has rdata 0 and err 0.
- Reset mid-operation: assert rst_i during BUS of a store. lsu_st_en_o = 0 in that cycle, no rsp. After release, a tie grants port 0 first.
- Withdrawn request: port 0 drops valid while port 1 is being served. Port 0 gets no ready and no response; busy_o returns to 0 after RESP.
